// File: rtl/emsggen_pkg.sv
// Shared helpers for the compressed-message generator: clog2, out_comp field
// offsets for the default geometry, and the clamp-at-zero subtract.
package emsggen_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_W  = 6;
    localparam int DEF_WC = 18;
    localparam int DEF_IW = clog2(DEF_WC);

    // out_comp layout, LSB up: signs, parity, idx, min2, min1
    localparam int PAR_BIT  = DEF_WC;
    localparam int IDX_LSB  = PAR_BIT + 1;
    localparam int MIN2_LSB = IDX_LSB + DEF_IW;
    localparam int MIN1_LSB = MIN2_LSB + DEF_W - 1;

    function automatic int unsigned sat0(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : 0;
    endfunction

endpackage

// File: rtl/emsggen_serial_min2_tree.sv
// Combinational min1/min2/argmin over P magnitude lanes; on equal values the
// lower lane keeps min1, so min1 == min2 is a legal result.
module min2_tree
    import emsggen_pkg::*;
#(
    parameter int W  = 6,
    parameter int P  = 3,
    parameter int LW = (P > 1) ? clog2(P) : 1
) (
    input  logic [P*(W-1)-1:0] i_mag,
    output logic [W-2:0]       o_min1,
    output logic [W-2:0]       o_min2,
    output logic [LW-1:0]      o_idx
);

    // NOTE: every output gets a value before the loop so no latch is inferred.
    always_comb begin
        logic [W-2:0] v;
        o_min1 = i_mag[W-2:0];
        o_min2 = '1;
        o_idx  = '0;
        for (int k = 1; k < P; k++) begin
            v = i_mag[k*(W-1) +: (W-1)];
            if (v < o_min1) begin
                o_min2 = o_min1;
                o_min1 = v;
                o_idx  = LW'(k);
            end else if (v < o_min2) begin
                o_min2 = v;
            end
        end
    end

endmodule

// File: rtl/emsggen_serial.sv
// Partial-parallel check-node compressed-message generator: folds P messages
// per beat into min1/min2/idx/signs/parity and emits one word per row.
module emsggen_serial
    import emsggen_pkg::*;
#(
    parameter int W  = 6,
    parameter int WC = 18,
    parameter int P  = 3,
    parameter int IW = clog2(WC),
    parameter int CW = 2*(W-1) + IW + WC + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*P-1:0] in_msg,
    input  logic [W-2:0]   offset,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  out_comp
);

    localparam int M  = W - 1;
    localparam int NB = WC / P;
    localparam int BW = (NB > 1) ? clog2(NB) : 1;
    localparam int LW = (P > 1) ? clog2(P) : 1;

    logic [BW-1:0] r_bcnt;
    logic [M-1:0]  r_min1, r_min2, r_off;
    logic [IW-1:0] r_idx;
    logic          r_par;
    logic [WC-1:0] r_signs;
    logic          r_out_valid;
    logic [CW-1:0] r_out_comp;

    logic [P*M-1:0] w_mags;
    logic [P-1:0]   w_bsigns;
    logic [M-1:0]   w_bmin1, w_bmin2, w_off;
    logic [LW-1:0]  w_lane;
    logic [IW-1:0]  w_bidx;
    logic           w_first, w_last, w_accept, w_load;
    logic [M-1:0]   w_min1, w_min2, w_min1_adj, w_min2_adj;
    logic [IW-1:0]  w_idx;
    logic           w_par;
    logic [WC-1:0]  w_signs;

    always_comb begin
        for (int k = 0; k < P; k++) begin
            w_mags[k*M +: M] = in_msg[k*W +: M];
            w_bsigns[k]      = in_msg[k*W + M];
        end
    end

    min2_tree #(.W(W), .P(P), .LW(LW)) u_tree (
        .i_mag  (w_mags),
        .o_min1 (w_bmin1),
        .o_min2 (w_bmin2),
        .o_idx  (w_lane)
    );

    assign w_first  = (r_bcnt == '0);
    assign w_last   = (r_bcnt == BW'(NB - 1));
    assign in_ready = !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_last;
    assign w_bidx   = IW'(int'(r_bcnt) * P + int'(w_lane));
    assign w_off    = w_first ? offset : r_off;

    // Beat 0 seeds the running values; later beats merge, a tie keeps the older min1.
    always_comb begin
        w_min1  = r_min1;
        w_min2  = r_min2;
        w_idx   = r_idx;
        w_par   = r_par ^ (^w_bsigns);
        w_signs = r_signs;
        if (w_first) begin
            w_min1  = w_bmin1;
            w_min2  = w_bmin2;
            w_idx   = w_bidx;
            w_par   = ^w_bsigns;
            w_signs = '0;
        end else if (w_bmin1 < r_min1) begin
            w_min1 = w_bmin1;
            w_min2 = (r_min1 < w_bmin2) ? r_min1 : w_bmin2;
            w_idx  = w_bidx;
        end else if (w_bmin1 < r_min2) begin
            w_min2 = w_bmin1;
        end
        for (int k = 0; k < P; k++) begin
            w_signs[IW'(int'(r_bcnt) * P + k)] = w_bsigns[k];
        end
    end

    assign w_min1_adj = M'(sat0(32'(w_min1), 32'(w_off)));
    assign w_min2_adj = M'(sat0(32'(w_min2), 32'(w_off)));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt  <= '0;
            r_min1  <= '0;
            r_min2  <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_signs <= '0;
            r_off   <= '0;
        end else if (w_accept) begin
            r_bcnt  <= w_last ? '0 : r_bcnt + 1'b1;
            r_min1  <= w_min1;
            r_min2  <= w_min2;
            r_idx   <= w_idx;
            r_par   <= w_par;
            r_signs <= w_signs;
            r_off   <= w_off;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_comp  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_comp  <= {w_min1_adj, w_min2_adj, w_idx, w_par, w_signs};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_comp  = r_out_comp;

endmodule

// File: tb/tb_emsggen_serial.sv
// Scoreboard bench for emsggen_serial: directed rows push hand-computed words,
// a negedge monitor pops and compares on every output handshake.
module tb_emsggen_serial;
    import emsggen_pkg::*;

    localparam int W  = 6;
    localparam int WC = 18;
    localparam int P  = 3;
    localparam int NB = WC / P;
    localparam int IW = clog2(WC);
    localparam int CW = 2*(W-1) + IW + WC + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [W*P-1:0] in_msg;
    logic [W-2:0]   offset;
    logic           out_valid, out_ready;
    logic [CW-1:0]  out_comp;

    always #5 clk = ~clk;

    emsggen_serial #(.W(W), .WC(WC), .P(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .offset    (offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_comp  (out_comp)
    );

    logic [CW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  row[WC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [CW-1:0] pack(input int m1, input int m2, input int idx,
                                           input logic par, input logic [WC-1:0] s);
        logic [CW-1:0] w;
        w = '0;
        w[MIN1_LSB +: W-1] = (W-1)'(m1);
        w[MIN2_LSB +: W-1] = (W-1)'(m2);
        w[IDX_LSB +: IW]   = IW'(idx);
        w[PAR_BIT]         = par;
        w[WC-1:0]          = s;
        return w;
    endfunction

    task automatic fill(input logic [W-1:0] v);
        for (int e = 0; e < WC; e++) row[e] = v;
    endtask

    // Later beats carry a junk offset so only the beat-0 value may matter.
    task automatic drive_beat(input int b, input logic [W-2:0] off);
        in_valid = 1'b1;
        in_msg   = {row[3*b+2], row[3*b+1], row[3*b]};
        offset   = (b == 0) ? off : '1;
    endtask

    task automatic send_beat(input int b, input logic [W-2:0] off);
        logic acc;
        int   budget;
        acc    = 1'b0;
        budget = 40;
        drive_beat(b, off);
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: beat %0d not accepted within 40 cycles", b);
        end
    endtask

    task automatic send_row(input logic [W-2:0] off, input int max_gap);
        for (int b = 0; b < NB; b++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
            send_beat(b, off);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %0h with empty queue", out_comp);
            end else begin
                check("out_comp", 64'(out_comp), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic row1();
        fill(6'd31);
        row[7]  = 6'd2;
        row[12] = 6'd5;
    endtask

    task automatic row2a();
        fill(6'd20);
        row[3] = 6'd4;
        row[9] = 6'd4;
    endtask

    task automatic row3();
        fill(6'd31);
        row[0]  = 6'h3F;
        row[5]  = 6'h20;
        row[10] = 6'd5;
        row[17] = 6'h3F;
    endtask

    initial begin
        logic [CW-1:0] exp_a;
        int            budget;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        offset    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_comp", 64'(out_comp), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single minimum plus runner-up in different beats; latency check.
        row1();
        exp_q.push_back(pack(2, 5, 7, 1'b0, '0));
        for (int b = 0; b < NB - 1; b++) send_beat(b, 5'd0);
        check("lat_before", 64'(out_valid), 64'd0);
        send_beat(NB - 1, 5'd0);
        check("lat_after", 64'(out_valid), 64'd1);

        // Cross-beat tie, then in-beat tie.
        row2a();
        exp_q.push_back(pack(4, 4, 3, 1'b0, '0));
        send_row(5'd0, 0);
        fill(6'd20);
        row[4] = 6'd1;
        row[5] = 6'd1;
        exp_q.push_back(pack(1, 1, 4, 1'b0, '0));
        send_row(5'd0, 0);

        // Signs incl. -0 on edge 5 (magnitude 0), offset saturation.
        row3();
        exp_q.push_back(pack(0, 2, 5, 1'b1, 18'h20021));
        send_row(5'd3, 0);

        // Backpressure: row A waits, row B streams up to its last beat.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        row1();
        exp_a = pack(2, 5, 7, 1'b0, '0);
        exp_q.push_back(exp_a);
        send_row(5'd0, 0);
        row2a();
        exp_q.push_back(pack(4, 4, 3, 1'b0, '0));
        for (int b = 0; b < NB - 1; b++) send_beat(b, 5'd0);
        drive_beat(NB - 1, 5'd0);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold_a", 64'(out_comp), 64'(exp_a));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(NB - 1, 5'd0);
        check("bp_no_gap", 64'(out_valid), 64'd1);

        // Random input gaps over several rows.
        row1();
        exp_q.push_back(pack(2, 5, 7, 1'b0, '0));
        send_row(5'd0, 2);
        row2a();
        exp_q.push_back(pack(4, 4, 3, 1'b0, '0));
        send_row(5'd0, 2);
        row3();
        exp_q.push_back(pack(0, 2, 5, 1'b1, 18'h20021));
        send_row(5'd3, 2);
        row1();
        exp_q.push_back(pack(1, 4, 7, 1'b0, '0));
        send_row(5'd1, 2);

        // Reset mid-row with a word pending; discarded beats must not leak.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        row1();
        send_row(5'd0, 0);
        fill(6'd31);
        row[1] = 6'h20;
        row[2] = 6'h21;
        for (int b = 0; b < 4; b++) send_beat(b, 5'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_comp", 64'(out_comp), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        row1();
        exp_q.push_back(pack(2, 5, 7, 1'b0, '0));
        send_row(5'd0, 0);

        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d words never appeared, expected 0 left", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
